sseg_scan_ctrl: RTL
===================

Name: sseg_scan_ctrl

Overview:
Scan controller for the Nexys A7 8-digit multiplexed seven-segment display. It time-shares the single segment bus across 8 anodes and inserts a blanking interval between digits to suppress ghosting. It also arbitrates the display between two 32-bit requesters (page A / page B, e.g. branch counter and taken-branch counter). The selected value is snapshotted once per frame so every digit of a frame comes from one coherent value. Sits in the board toplevel on clk_core, between SoC status counters and the an/ca..cg pins.

Parameters:
PRESCALE, 100000, clock cycles per digit slot (blank + drive); must be > BLANK_CYCLES
BLANK_CYCLES, 1000, cycles per slot with all anodes off; 0 = no blank phase
PAGE_FRAMES, 64, frames per page in alternate mode; must be >= 1

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
i_val_a  in  32  page A value, 8 hex nibbles, nibble 0 on digit 0
i_val_b  in  32  page B value
i_mode  in  2  0 = A only, 1 = B only, 2 = alternate, 3 = treated as 2
i_freeze  in  1  hold current snapshot and page
i_dp_mask  in  8  decimal point enable per digit
o_an  out  8  anodes, active-low, one-hot-low during drive
o_seg  out  7  segments, active-low, bit0 = a … bit6 = g
o_dp  out  1  decimal point, active-low
o_page  out  1  page currently displayed (0 = A, 1 = B)
o_frame  out  1  one-cycle pulse when digit 7 slot ends

Behaviour:
- Reset values:
  - o_an = 8'hFF, o_seg = 7'h7F, o_dp = 1, o_page = 0, o_frame = 0
  - digit = 0, slot counter = 0, frame counter = 0, snapshot = 0
  - FSM state = BLANK, or DRIVE if BLANK_CYCLES = 0
- Reset mid-operation returns to reset values on the next edge.
- All outputs are registered and change on the same edge the FSM changes state or digit.
- Slot counter: width $clog2(PRESCALE), counts 0..PRESCALE-1 and wraps.
  - BLANK for counts 0..BLANK_CYCLES-1: o_an = FF, o_seg = 7F, o_dp = 1.
  - DRIVE for counts BLANK_CYCLES..PRESCALE-1:
    - o_an[digit] = 0, all other anodes 1
    - o_seg = decode(snapshot[4*digit+3:4*digit])
    - o_dp = ~i_dp_mask[digit], sampled live
- Slot-end edge (count == PRESCALE-1): counter → 0, digit → digit+1 mod 8.
  - When digit == 7: o_frame = 1 for one cycle, the new frame starts, and the snapshot-update edge below happens on this same edge.
- Snapshot update on the frame-start edge, unless i_freeze = 1:
  - Page select: mode 0 → page 0; mode 1 → page 1.
  - Mode 2/3: frame counter increments; when it reaches PAGE_FRAMES-1 it resets to 0 and the page toggles.
  - Snapshot is loaded from the newly selected page value.
  - Mode 0/1 clears the frame counter.
- i_mode or i_val changes mid-frame do not affect the current frame.
- i_freeze = 1 holds snapshot, page and frame counter; scanning continues.
- Decode, active-low hex, 0..F:
  40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E
- Frame period = 8*PRESCALE cycles exactly.
- No sequence may drive two anodes low in the same cycle.

Optional Feature:
SSEG_LEADING_ZERO_BLANK_EN
- Defined: during DRIVE, digits above the most significant nonzero nibble of the snapshot output o_seg = 7F.
  - Their anode still strobes, so timing is unchanged.
  - Digit 0 is always shown, so a value of 0 displays "0".
  - o_dp is still driven per i_dp_mask.
- Undefined: all 8 digits are always decoded.

Test Plan:
Bench parameters for all scenarios: PRESCALE = 8, BLANK_CYCLES = 2, PAGE_FRAMES = 2.
1. Reset, mode 0, val_a = 32'h76543210 → first frame:
   - each digit shows 2 cycles an = FF, then 6 cycles with an = FE, FD, … 7F
   - seg sequence 40, 79, 24, 30, 19, 12, 02, 78
   - o_frame pulses every 64 cycles
2. Change val_a to 32'hFFFFFFFF while digit 3 is driven → digits 4..7 still show the old nibbles; next frame shows 0E on all digits.
3. Mode 2, val_a = 32'h1, val_b = 32'h2, start from reset → o_page sequence by frame 0, 0, 1, 1, 0; digit 0 seg 79, 79, 24, 24, 79.
4. i_freeze = 1 across two frame boundaries in mode 2 → o_page and digit values unchanged; anodes keep scanning.
5. rst asserted mid-DRIVE of digit 5 → next cycle o_an = FF, o_seg = 7F, o_page = 0; scan restarts at digit 0 with 2 blank cycles.
6. SSEG_LEADING_ZERO_BLANK_EN defined:
   - val_a = 32'h00000A0 → digits 0, 1 show 40, 08; digits 2..7 show 7F
   - val_a = 0 → digit 0 shows 40
   - i_dp_mask = 8'h80 → o_dp = 0 only while an = 7F

Source files
------------

// File: rtl/sseg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scan controller with two-page arbitration and per-frame snapshot.
// Optional build macro SSEG_LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero nibble.
module sseg_scan_ctrl #(
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int PAGE_FRAMES  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_val_a,
  input  logic [31:0] i_val_b,
  input  logic [1:0]  i_mode,
  input  logic        i_freeze,
  input  logic [7:0]  i_dp_mask,
  output logic [7:0]  o_an,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic        o_page,
  output logic        o_frame
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int FC_W  = (PAGE_FRAMES > 1) ? $clog2(PAGE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);
  localparam logic [FC_W-1:0]  FC_LAST   = FC_W'(PAGE_FRAMES - 1);
  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

  typedef enum logic [0:0] {BLANK = 1'b0, DRIVE = 1'b1} state_t;
  localparam state_t RST_STATE = HAS_BLANK ? BLANK : DRIVE;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       digit, digit_nxt;
  logic [31:0]      snap, snap_nxt;
  logic             page, page_nxt;
  logic [FC_W-1:0]  fc, fc_nxt;
  logic             prime;
  logic             load;
  logic             frame_nxt;
  logic [3:0]       nib;
  logic             show;
  logic [7:0]       an_nxt;
  logic [6:0]       seg_nxt;
  logic             dp_nxt;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

`ifdef SSEG_LEADING_ZERO_BLANK_EN
  // Index of the highest nonzero nibble; digit 0 when the value is zero.
  function automatic logic [2:0] top_digit(input logic [31:0] v);
    logic [2:0] t;
    t = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (v[4*i +: 4] != 4'h0) t = 3'(i);
    end
    return t;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RST_STATE;
      cnt     <= '0;
      digit   <= 3'd0;
      snap    <= 32'd0;
      page    <= 1'b0;
      fc      <= '0;
      prime   <= 1'b1;
      o_an    <= 8'hFF;
      o_seg   <= 7'h7F;
      o_dp    <= 1'b1;
      o_page  <= 1'b0;
      o_frame <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      digit   <= digit_nxt;
      snap    <= snap_nxt;
      page    <= page_nxt;
      fc      <= fc_nxt;
      prime   <= 1'b0;
      o_an    <= an_nxt;
      o_seg   <= seg_nxt;
      o_dp    <= dp_nxt;
      o_page  <= page_nxt;
      o_frame <= frame_nxt;
    end
  end

  // Slot timing, frame boundary and snapshot/page selection.
  always_comb begin
    cnt_nxt   = cnt + CNT_W'(1);
    digit_nxt = digit;
    snap_nxt  = snap;
    page_nxt  = page;
    fc_nxt    = fc;
    frame_nxt = 1'b0;
    load      = prime;
    state_nxt = state;

    if (cnt == CNT_LAST) begin
      cnt_nxt   = '0;
      digit_nxt = digit + 3'd1;
      if (digit == 3'd7) begin
        frame_nxt = 1'b1;
        load      = 1'b1;
      end
    end

    // The first cycle after reset loads the snapshot without advancing the page rotation.
    if (load && !i_freeze) begin
      case (i_mode)
        2'd0: begin
          page_nxt = 1'b0;
          fc_nxt   = '0;
        end
        2'd1: begin
          page_nxt = 1'b1;
          fc_nxt   = '0;
        end
        default: begin
          if (!prime) begin
            if (fc == FC_LAST) begin
              fc_nxt   = '0;
              page_nxt = ~page;
            end else begin
              fc_nxt = fc + FC_W'(1);
            end
          end
        end
      endcase
      snap_nxt = page_nxt ? i_val_b : i_val_a;
    end

    case (state)
      BLANK:   if (cnt_nxt == BLANK_LIM) state_nxt = DRIVE;
      DRIVE:   if (HAS_BLANK && (cnt_nxt == '0)) state_nxt = BLANK;
      default: state_nxt = RST_STATE;
    endcase
  end

  // Pin values for the upcoming cycle, derived from next-state so they switch with the FSM.
  always_comb begin
    nib = snap_nxt[{digit_nxt, 2'b00} +: 4];
`ifdef SSEG_LEADING_ZERO_BLANK_EN
    show = (digit_nxt <= top_digit(snap_nxt));
`else
    show = 1'b1;
`endif
    an_nxt  = 8'hFF;
    seg_nxt = 7'h7F;
    dp_nxt  = 1'b1;
    if (state_nxt == DRIVE) begin
      an_nxt  = ~(8'b1 << digit_nxt);
      seg_nxt = show ? hex_to_seg(nib) : 7'h7F;
      dp_nxt  = ~i_dp_mask[digit_nxt];
    end
  end

endmodule
